// File: rtl/anc_phase_seq.sv
// anc_phase_seq: phase sequencer for the ANC audio datapath.
// Runs OFZ (offline secondary-path identification), a coefficient hand-off,
// a settle window and then online ANC, stepping cyc_cnt on aud_lrc falling edges.
// Optional build macro: ANC_SEQ_WATCHDOG_EN adds a frame-loss watchdog and a FAULT state.
module anc_phase_seq #(
  parameter int CYC_LEN       = 2048,
  parameter int OFZ_PASSES    = 4,
  parameter int SETTLE_FRAMES = 16,
  parameter int WDOG_CYCLES   = 256
) (
  input  logic        aud_bclk,
  input  logic        rst_n,
  input  logic        aud_lrc,
  input  logic        start,
  input  logic        abort,
  input  logic        coef_ack,
  output logic [12:0] cyc_cnt,
  output logic        OFZ_ok,
  output logic        ofz_en,
  output logic        coef_req,
  output logic        frame_stb,
  output logic [7:0]  pass_cnt,
  output logic        busy,
  output logic        fault
);

  localparam logic [12:0] CYC_MAX    = 13'(CYC_LEN - 1);
  localparam logic [7:0]  PASS_TGT   = 8'(OFZ_PASSES);
  localparam logic [7:0]  SETTLE_MAX = 8'(SETTLE_FRAMES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OFZ,
    S_HANDOFF,
    S_SETTLE,
    S_ANC
`ifdef ANC_SEQ_WATCHDOG_EN
    , S_FAULT
`endif
  } state_t;

  state_t      state_reg, state_next;
  logic        lrc_q_reg;
  logic [12:0] cyc_cnt_reg, cyc_cnt_next;
  logic [7:0]  pass_cnt_reg, pass_cnt_next;
  logic [7:0]  settle_cnt_reg, settle_cnt_next;
  logic        frame_stb_reg, frame_stb_next;
  logic        ofz_ok_reg, ofz_en_reg, coef_req_reg, busy_reg;
  logic        frame_edge;
  logic [7:0]  pass_inc;
  logic        wdog_trip;

  // A frame boundary is the falling edge of aud_lrc
  assign frame_edge = lrc_q_reg & ~aud_lrc;
  assign pass_inc   = pass_cnt_reg + 8'd1;

`ifdef ANC_SEQ_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_cnt_reg, wdog_cnt_next;
  logic              fault_reg;

  // Watchdog: counts cycles since the last edge while a run depends on frames
  always_comb begin
    wdog_cnt_next = wdog_cnt_reg;
    wdog_trip     = 1'b0;
    if (abort || frame_edge) begin
      wdog_cnt_next = '0;
    end else if (state_reg == S_OFZ || state_reg == S_SETTLE || state_reg == S_ANC) begin
      if (wdog_cnt_reg == WDOG_W'(WDOG_CYCLES - 1)) begin
        wdog_trip     = 1'b1;
        wdog_cnt_next = '0;
      end else begin
        wdog_cnt_next = wdog_cnt_reg + 1'b1;
      end
    end else begin
      wdog_cnt_next = '0;
    end
  end

  // Watchdog counter and registered fault flag
  always_ff @(posedge aud_bclk) begin
    if (!rst_n) begin
      wdog_cnt_reg <= '0;
      fault_reg    <= 1'b0;
    end else begin
      wdog_cnt_reg <= wdog_cnt_next;
      fault_reg    <= (state_next == S_FAULT);
    end
  end

  assign fault = fault_reg;
`else
  // No watchdog in this build: fault is constant low (expression keeps WDOG_CYCLES referenced)
  localparam logic FAULT_TIE = (WDOG_CYCLES < 0);
  assign wdog_trip = 1'b0;
  assign fault     = FAULT_TIE;
`endif

  // Next-state and counter decisions; abort beats watchdog beats edge/ack beats start
  always_comb begin
    state_next      = state_reg;
    cyc_cnt_next    = cyc_cnt_reg;
    pass_cnt_next   = pass_cnt_reg;
    settle_cnt_next = settle_cnt_reg;
    frame_stb_next  = 1'b0;
    if (abort || wdog_trip) begin
      cyc_cnt_next    = '0;
      pass_cnt_next   = '0;
      settle_cnt_next = '0;
`ifdef ANC_SEQ_WATCHDOG_EN
      state_next      = abort ? S_IDLE : S_FAULT;
`else
      state_next      = S_IDLE;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          cyc_cnt_next    = '0;
          pass_cnt_next   = '0;
          settle_cnt_next = '0;
          if (start) state_next = S_OFZ;
        end
        S_OFZ: begin
          if (frame_edge) begin
            frame_stb_next = 1'b1;
            if (cyc_cnt_reg == CYC_MAX) begin
              cyc_cnt_next  = '0;
              pass_cnt_next = pass_inc;
              if (pass_inc == PASS_TGT) state_next = S_HANDOFF;
            end else begin
              cyc_cnt_next = cyc_cnt_reg + 13'd1;
            end
          end
        end
        S_HANDOFF: begin
          cyc_cnt_next = '0;
          if (coef_ack) begin
            state_next      = S_SETTLE;
            settle_cnt_next = '0;
          end
        end
        S_SETTLE: begin
          cyc_cnt_next = '0;
          if (frame_edge) begin
            frame_stb_next = 1'b1;
            if (settle_cnt_reg == SETTLE_MAX) begin
              state_next      = S_ANC;
              settle_cnt_next = '0;
            end else begin
              settle_cnt_next = settle_cnt_reg + 8'd1;
            end
          end
        end
        S_ANC: begin
          if (frame_edge) begin
            frame_stb_next = 1'b1;
            cyc_cnt_next   = (cyc_cnt_reg == CYC_MAX) ? 13'd0 : cyc_cnt_reg + 13'd1;
          end
        end
`ifdef ANC_SEQ_WATCHDOG_EN
        S_FAULT: begin
          cyc_cnt_next    = '0;
          pass_cnt_next   = '0;
          settle_cnt_next = '0;
        end
`endif
        default: begin
          state_next      = S_IDLE;
          cyc_cnt_next    = '0;
          pass_cnt_next   = '0;
          settle_cnt_next = '0;
        end
      endcase
    end
  end

  // State, counters and registered phase flags (flags decoded from the next state)
  always_ff @(posedge aud_bclk) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      lrc_q_reg      <= 1'b0;
      cyc_cnt_reg    <= '0;
      pass_cnt_reg   <= '0;
      settle_cnt_reg <= '0;
      frame_stb_reg  <= 1'b0;
      ofz_ok_reg     <= 1'b0;
      ofz_en_reg     <= 1'b0;
      coef_req_reg   <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      lrc_q_reg      <= aud_lrc;
      cyc_cnt_reg    <= cyc_cnt_next;
      pass_cnt_reg   <= pass_cnt_next;
      settle_cnt_reg <= settle_cnt_next;
      frame_stb_reg  <= frame_stb_next;
      ofz_ok_reg     <= (state_next == S_ANC);
      ofz_en_reg     <= (state_next == S_OFZ);
      coef_req_reg   <= (state_next == S_HANDOFF);
`ifdef ANC_SEQ_WATCHDOG_EN
      busy_reg       <= (state_next != S_IDLE) && (state_next != S_FAULT);
`else
      busy_reg       <= (state_next != S_IDLE);
`endif
    end
  end

  assign cyc_cnt   = cyc_cnt_reg;
  assign pass_cnt  = pass_cnt_reg;
  assign frame_stb = frame_stb_reg;
  assign OFZ_ok    = ofz_ok_reg;
  assign ofz_en    = ofz_en_reg;
  assign coef_req  = coef_req_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_anc_phase_seq.sv
// tb_anc_phase_seq: scoreboard bench for anc_phase_seq.
// Each generated aud_lrc falling edge pushes the expected post-edge outputs;
// a monitor pops and compares on every frame_stb pulse.
`timescale 1ns/1ps
module tb_anc_phase_seq;

  localparam int CYC_LEN       = 8;
  localparam int OFZ_PASSES    = 2;
  localparam int SETTLE_FRAMES = 3;
  localparam int WDOG_CYCLES   = 256;
  localparam int HALF          = 32;

  logic        aud_bclk = 1'b0;
  logic        rst_n    = 1'b0;
  logic        aud_lrc  = 1'b0;
  logic        start    = 1'b0;
  logic        abort    = 1'b0;
  logic        coef_ack = 1'b0;
  logic [12:0] cyc_cnt;
  logic        OFZ_ok, ofz_en, coef_req, frame_stb;
  logic [7:0]  pass_cnt;
  logic        busy, fault;

  typedef struct packed {
    logic [12:0] cyc;
    logic [7:0]  pass;
    logic        ofz_en;
    logic        ofz_ok;
    logic        coef_req;
    logic        busy;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc_no = 0;
  int   last_stb_cyc = 0;
  int   fault_cyc;

  anc_phase_seq #(
    .CYC_LEN       (CYC_LEN),
    .OFZ_PASSES    (OFZ_PASSES),
    .SETTLE_FRAMES (SETTLE_FRAMES),
    .WDOG_CYCLES   (WDOG_CYCLES)
  ) dut (
    .aud_bclk  (aud_bclk),
    .rst_n     (rst_n),
    .aud_lrc   (aud_lrc),
    .start     (start),
    .abort     (abort),
    .coef_ack  (coef_ack),
    .cyc_cnt   (cyc_cnt),
    .OFZ_ok    (OFZ_ok),
    .ofz_en    (ofz_en),
    .coef_req  (coef_req),
    .frame_stb (frame_stb),
    .pass_cnt  (pass_cnt),
    .busy      (busy),
    .fault     (fault)
  );

  always #5 aud_bclk = ~aud_bclk;

  always @(posedge aud_bclk) cyc_no <= cyc_no + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input int c, input int p, input bit en, input bit ok, input bit req);
    exp_t e;
    e.cyc      = 13'(c);
    e.pass     = 8'(p);
    e.ofz_en   = en;
    e.ofz_ok   = ok;
    e.coef_req = req;
    e.busy     = 1'b1;
    return e;
  endfunction

  // Monitor: every frame_stb pulse must match the oldest pushed expectation
  always @(negedge aud_bclk) begin
    if (frame_stb) begin
      last_stb_cyc <= cyc_no;
      if (sb_q.size() == 0) begin
        check_eq("stb_unexp", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("stb_cyc",  int'(cyc_cnt),  int'(mon_e.cyc));
        check_eq("stb_pass", int'(pass_cnt), int'(mon_e.pass));
        check_eq("stb_en",   int'(ofz_en),   int'(mon_e.ofz_en));
        check_eq("stb_ok",   int'(OFZ_ok),   int'(mon_e.ofz_ok));
        check_eq("stb_req",  int'(coef_req), int'(mon_e.coef_req));
        check_eq("stb_busy", int'(busy),     int'(mon_e.busy));
        $display("stb t=%0d cyc=%0d pass=%0d en=%b ok=%b req=%b",
                 cyc_no, cyc_cnt, pass_cnt, ofz_en, OFZ_ok, coef_req);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge aud_bclk);
    #1;
  endtask

  // One aud_lrc period; the falling edge at mid-period is the frame edge
  task automatic frame(input bit push_it, input exp_t e);
    aud_lrc = 1'b1;
    tick(HALF);
    if (push_it) sb_q.push_back(e);
    aud_lrc = 1'b0;
    tick(HALF);
  endtask

  task automatic check_idle(input string p);
    check_eq({p, "_cyc"},  int'(cyc_cnt),   0);
    check_eq({p, "_ok"},   int'(OFZ_ok),    0);
    check_eq({p, "_en"},   int'(ofz_en),    0);
    check_eq({p, "_req"},  int'(coef_req),  0);
    check_eq({p, "_stb"},  int'(frame_stb), 0);
    check_eq({p, "_pass"}, int'(pass_cnt),  0);
    check_eq({p, "_busy"}, int'(busy),      0);
    check_eq({p, "_flt"},  int'(fault),     0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check_eq("start_busy", int'(busy),    1);
    check_eq("start_en",   int'(ofz_en),  1);
    check_eq("start_cyc",  int'(cyc_cnt), 0);
  endtask

  task automatic run_ofz();
    for (int k = 1; k <= CYC_LEN * OFZ_PASSES; k++) begin
      frame(1'b1, mk(k % CYC_LEN, k / CYC_LEN, k < CYC_LEN * OFZ_PASSES, 1'b0,
                     k == CYC_LEN * OFZ_PASSES));
    end
  endtask

  task automatic do_ack();
    coef_ack = 1'b1;
    tick(1);
    coef_ack = 1'b0;
    check_eq("ack_req", int'(coef_req), 0);
  endtask

  task automatic run_settle(input int n);
    for (int j = 1; j <= n; j++) begin
      frame(1'b1, mk(0, OFZ_PASSES, 1'b0, j == SETTLE_FRAMES, 1'b0));
    end
  endtask

  task automatic run_anc(input int n);
    for (int j = 1; j <= n; j++) begin
      frame(1'b1, mk(j % CYC_LEN, OFZ_PASSES, 1'b0, 1'b1, 1'b0));
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    tick(4);
    rst_n = 1'b1;
    tick(1);
    check_idle("reset");

    // Full OFZ run, then a long hand-off wait
    do_start();
    run_ofz();
    for (int i = 0; i < 8; i++) begin
      frame(1'b0, '0);
      check_eq("ho_req", int'(coef_req), 1);
      check_eq("ho_cyc", int'(cyc_cnt),  0);
    end
    check_eq("ho_pass", int'(pass_cnt), OFZ_PASSES);
    check_eq("ho_en",   int'(ofz_en),   0);
    do_ack();
    run_settle(SETTLE_FRAMES);

    // ANC counting with wrap, abort at cyc_cnt=5
    run_anc(13);
    check_eq("anc_cyc5", int'(cyc_cnt), 5);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check_idle("abort");

    // Restart; start pulses during OFZ must not disturb the counters
    do_start();
    for (int k = 1; k <= 3; k++) begin
      frame(1'b1, mk(k, 0, 1'b1, 1'b0, 1'b0));
      start = 1'b1;
      tick(1);
      start = 1'b0;
      check_eq("start_ign", int'(cyc_cnt), k);
    end
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check_idle("abort2");

    // start together with abort in IDLE keeps the block idle
    start = 1'b1;
    abort = 1'b1;
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    check_idle("st_ab");
    frame(1'b0, '0);
    check_idle("st_ab2");

    // Synchronous reset pulse during SETTLE
    do_start();
    run_ofz();
    do_ack();
    run_settle(1);
    rst_n = 1'b0;
    #3;
    check_eq("rst_sync", int'(busy), 1);
    tick(1);
    rst_n = 1'b1;
    check_idle("rst_mid");

    // Lose frames in ANC
    do_start();
    run_ofz();
    do_ack();
    run_settle(SETTLE_FRAMES);
    run_anc(2);
    fault_cyc = -1;
    for (int i = 0; i < 400 && fault_cyc < 0; i++) begin
      if (fault) fault_cyc = cyc_no;
      else tick(1);
    end
`ifdef ANC_SEQ_WATCHDOG_EN
    check_eq("wdog_lat",  fault_cyc - last_stb_cyc, WDOG_CYCLES);
    check_eq("wdog_busy", int'(busy),   0);
    check_eq("wdog_ok",   int'(OFZ_ok), 0);
`else
    check_eq("fault_tied", int'(fault), 0);
    check_eq("anc_hold",   int'(OFZ_ok), 1);
`endif
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check_idle("post_flt");

    tick(4);
    check_eq("sb_left", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
